// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and helpers for the register write arbiter.
//   STATS_W   - width of one per-requester grant counter
//   MAX_REQ   - largest supported requester count (index width fixed at 3 bits)
//   stat_cnt_t- saturating grant counter type (used when REG_ARB_STATS_EN is defined)
//   rr_pick   - round-robin search: first valid requester at or after ptr,
//               wrapping modulo num_req; returns {found, idx}.
package reg_arb_pkg;

  localparam int STATS_W = 16;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef logic [STATS_W-1:0] stat_cnt_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int                 num_req);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < num_req && !res.found) begin
        cand = (int'(ptr) + k) % num_req;
        if (valid[cand]) begin
          res.found = 1'b1;
          res.idx   = IDX_W'(cand);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant selection with a rotating priority pointer.
//   clk, rst   - clock, asynchronous active-low reset (pointer returns to 0)
//   hold       - 1 suppresses every grant and freezes the pointer
//   req_valid  - per-requester request
//   req_ready  - one-hot grant (combinational, 0 while in reset)
//   gnt_idx    - index of the granted requester (valid when gnt_vld=1)
//   gnt_vld    - a transfer happens at the next rising edge
module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0]   ptr;
  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
  end

  assign pick = rr_pick(valid_ext, ptr, NUM_REQ);

  // Reset is folded into the grant so req_ready is 0 while rst is low.
  assign gnt_vld = rst & ~hold & pick.found;
  assign gnt_idx = pick.idx;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = gnt_vld && (pick.idx == IDX_W'(i));
    end
  end

  // Winner drops to lowest priority; no transfer leaves the pointer alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (int'(pick.idx) == NUM_REQ - 1) ? '0 : pick.idx + 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the write port of a NUM_REGS x N register bank
// among NUM_REQ requesters using round-robin valid/ready arbitration.
//
// Handshake: a transfer happens at a rising edge where req_valid[i] and
// req_ready[i] are both 1; a requester keeps valid/addr/data stable until
// granted and may withdraw by dropping valid before that.
//
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   hold       - 1 blocks new grants (stall/flush); in-flight write still issues
//   req_valid  - per-requester request
//   req_addr   - packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   - packed data, requester i at [i*N +: N]
//   req_ready  - one-hot combinational grant
//   reg_en     - registered one-hot bank write enable (one cycle per transfer)
//   reg_d      - registered write data (holds when idle)
//   addr_err   - sticky: a granted address was >= NUM_REGS
//   grant_cnt  - only with REG_ARB_STATS_EN: 16-bit saturating per-requester
//                transfer counters, requester i at [i*16 +: 16]
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int N        = 32,
  parameter  int NUM_REQ  = 3,
  parameter  int NUM_REGS = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*N-1:0]      req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REGS-1:0]       reg_en,
  output logic [N-1:0]              reg_d,
  output logic                      addr_err
`ifdef REG_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] grant_cnt
`endif
);

  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_vld;
  logic [ADDR_W-1:0]   sel_addr;
  logic [N-1:0]        sel_data;
  logic                in_range;
  logic [NUM_REGS-1:0] en_nxt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  // Select the winner's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*N +: N];
      end
    end
  end

  // NUM_REGS need not be a power of two, so high codes may have no register.
  assign in_range = 32'(sel_addr) < 32'(NUM_REGS);

  always_comb begin
    en_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      en_nxt[r] = gnt_vld && in_range && (sel_addr == ADDR_W'(r));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_en   <= '0;
      reg_d    <= '0;
      addr_err <= 1'b0;
    end else begin
      reg_en <= en_nxt;
      if (gnt_vld) begin
        reg_d <= sel_data;
      end
      if (gnt_vld && !in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

`ifdef REG_ARB_STATS_EN
  stat_cnt_t cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_vld && gnt_idx == IDX_W'(i) && cnt[i] != '1) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*STATS_W +: STATS_W] = cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter (NUM_REGS=12 so out-of-range codes exist).
// Build with REG_ARB_STATS_EN defined to also exercise the grant counters.
module tb_reg_write_arbiter;

  localparam int N        = 32;
  localparam int NUM_REQ  = 3;
  localparam int NUM_REGS = 12;
  localparam int ADDR_W   = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      hold = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*N-1:0]      req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REGS-1:0]       reg_en;
  logic [N-1:0]              reg_d;
  logic                      addr_err;
`ifdef REG_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

  reg_write_arbiter #(
    .N        (N),
    .NUM_REQ  (NUM_REQ),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .reg_en    (reg_en),
    .reg_d     (reg_d),
    .addr_err  (addr_err)
`ifdef REG_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int                  m_ptr;
  logic [NUM_REGS-1:0] m_en;
  logic [N-1:0]        m_d;
  logic                m_err;
  int                  m_cnt [NUM_REQ];
  logic [N-1:0]        exp_q [$];

  function automatic void model_reset();
    m_ptr = 0;
    m_en  = '0;
    m_d   = '0;
    m_err = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
  endfunction

  // Index of the requester that should win now, or -1.
  function automatic int model_winner();
    int i;
    if (!rst || hold) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (m_ptr + k) % NUM_REQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] model_ready();
    int w;
    w = model_winner();
    if (w < 0) return '0;
    return NUM_REQ'(1) << w;
  endfunction

  // Advance one rising edge and update the model from the current inputs.
  task automatic advance(output int winner);
    int a;
    winner = model_winner();
    @(posedge clk);
    m_en = '0;
    if (winner >= 0) begin
      a = int'(req_addr[winner*ADDR_W +: ADDR_W]);
      if (a < NUM_REGS) begin
        m_en = NUM_REGS'(1) << a;
        m_d  = req_data[winner*N +: N];
      end else begin
        m_err = 1'b1;
      end
      m_ptr = (winner + 1) % NUM_REQ;
      if (m_cnt[winner] < 65535) m_cnt[winner]++;
    end
    #1;
  endtask

  task automatic set_req(input int i, input int addr, input logic [N-1:0] data);
    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    req_data[i*N +: N]           = data;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int w;
    rst       = 1'b0;
    req_valid = 3'b111;
    hold      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, i, N'(i + 1));
    model_reset();
    @(negedge clk);
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", req_ready); end
    total++; if (reg_en !== '0) begin bad++; $display("FAIL reset_en got=%h want=0", reg_en); end
    total++; if (reg_d !== '0) begin bad++; $display("FAIL reset_d got=%h want=0", reg_d); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", addr_err); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL reset_first_grant got=%b want=001", req_ready); end
    advance(w);
    req_valid = '0;
    advance(w);
  endtask

  task automatic test_single_write();
    int w;
    req_valid = 3'b010;
    set_req(1, 5, 32'h11111);
    @(negedge clk);
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b want=010", req_ready); end
    advance(w);
    req_valid = '0;
    @(negedge clk);
    total++; if (reg_en !== 12'h020 || reg_en !== m_en) begin bad++; $display("FAIL single_en got=%h want=020", reg_en); end
    total++; if (reg_d !== 32'h11111) begin bad++; $display("FAIL single_d got=%h want=00011111", reg_d); end
    advance(w);
    @(negedge clk);
    total++; if (reg_en !== '0) begin bad++; $display("FAIL single_idle_en got=%h want=0", reg_en); end
    total++; if (reg_d !== 32'h11111) begin bad++; $display("FAIL single_hold_d got=%h want=00011111", reg_d); end
  endtask

  task automatic test_round_robin();
    int w;
    logic [N-1:0] rr_data [NUM_REQ];
    logic [N-1:0] e;
    rr_data[0] = 32'hAAAAA;
    rr_data[1] = 32'h44444;
    rr_data[2] = 32'h77777;
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, i + 1, rr_data[i]);
    req_valid = 3'b111;
    exp_q.delete();
    for (int c = 0; c <= 6; c++) begin
      if (c == 6) req_valid = '0;
      @(negedge clk);
      if (c < 6) begin
        total++;
        if (req_ready !== (NUM_REQ'(1) << (c % NUM_REQ))) begin
          bad++; $display("FAIL rr_order cycle=%0d got=%b want_idx=%0d", c, req_ready, c % NUM_REQ);
        end
        exp_q.push_back(rr_data[c % NUM_REQ]);
      end
      if (c > 0) begin
        e = exp_q.pop_front();
        total++; if (reg_en !== m_en || reg_en == '0) begin bad++; $display("FAIL rr_en cycle=%0d got=%h want=%h", c, reg_en, m_en); end
        total++; if (reg_d !== e) begin bad++; $display("FAIL rr_d cycle=%0d got=%h want=%h", c, reg_d, e); end
      end
      advance(w);
    end
  endtask

  task automatic test_hold();
    int w;
    req_valid = 3'b100;
    set_req(2, 7, 32'h12345);
    hold = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL hold_pre_ready got=%b want=100", req_ready); end
    advance(w);
    set_req(2, 9, 32'h54321);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL hold_ready cycle=%0d got=%b want=000", c, req_ready); end
      total++; if (reg_en !== m_en) begin bad++; $display("FAIL hold_en cycle=%0d got=%h want=%h", c, reg_en, m_en); end
      advance(w);
    end
    hold = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL hold_release_ready got=%b want=100", req_ready); end
    advance(w);
    req_valid = '0;
    @(negedge clk);
    total++; if (reg_en !== 12'h200 || reg_d !== 32'h54321) begin bad++; $display("FAIL hold_release_write got en=%h d=%h want en=200 d=00054321", reg_en, reg_d); end
    advance(w);
  endtask

  task automatic test_out_of_range();
    int w;
    pulse_reset();
    req_valid = 3'b001;
    set_req(0, 14, 32'hEEEEE);
    @(negedge clk);
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL oor_ready got=%b want=001", req_ready); end
    advance(w);
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (reg_en !== '0) begin bad++; $display("FAIL oor_en cycle=%0d got=%h want=0", c, reg_en); end
      total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oor_err cycle=%0d got=%b want=1", c, addr_err); end
      advance(w);
    end
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oor_err_clear got=%b want=0", addr_err); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset_mid();
    int w;
    req_valid = 3'b001;
    set_req(0, 3, 32'hCAFE0);
    advance(w);
    req_valid = '0;
    total++; if (reg_en !== 12'h008) begin bad++; $display("FAIL midrst_pre_en got=%h want=008", reg_en); end
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (reg_en !== '0 || reg_d !== '0) begin bad++; $display("FAIL midrst_clear got en=%h d=%h want 0", reg_en, reg_d); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    int w;
    logic [NUM_REQ-1:0] exp_r;
    pulse_reset();
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      hold = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      exp_r = model_ready();
      total++; if (req_ready !== exp_r) begin bad++; $display("FAIL rand_ready cycle=%0d got=%b want=%b", c, req_ready, exp_r); end
      total++; if (reg_en !== m_en) begin bad++; $display("FAIL rand_en cycle=%0d got=%h want=%h", c, reg_en, m_en); end
      if (m_en != '0) begin
        total++; if (reg_d !== m_d) begin bad++; $display("FAIL rand_d cycle=%0d got=%h want=%h", c, reg_d, m_d); end
      end
      total++; if (addr_err !== m_err) begin bad++; $display("FAIL rand_err cycle=%0d got=%b want=%b", c, addr_err, m_err); end
      advance(w);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || w == i) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_req(i, ($urandom_range(0, 15) == 0) ? 13 : int'($urandom_range(0, NUM_REGS - 1)), $urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    hold      = 1'b0;
    advance(w);
  endtask

`ifdef REG_ARB_STATS_EN
  task automatic test_stats();
    int w;
    pulse_reset();
    req_valid = 3'b001;
    set_req(0, 0, 32'h1);
    for (int c = 0; c < 70000; c++) advance(w);
    req_valid = '0;
    @(negedge clk);
    total++; if (grant_cnt[15:0] !== 16'hFFFF || m_cnt[0] != 65535) begin bad++; $display("FAIL stats_sat got=%h want=ffff", grant_cnt[15:0]); end
    total++; if (grant_cnt[47:16] !== '0) begin bad++; $display("FAIL stats_others got=%h want=0", grant_cnt[47:16]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_hold();
    test_out_of_range();
    test_reset_mid();
    test_random();
`ifdef REG_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the write port of a bank of NUM_REGS N-bit `register` instances among NUM_REQ requesters, e.g. the AES round unit, key expansion and load unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives one-hot per-register write enables (`en`) and a common data bus (`D`) from a registered output stage.
- Sits between the SIMD execution units and the vector register bank.

Parameters:
- N, 32, data width of each register.
- NUM_REQ, 3, number of requesters (2..8).
- NUM_REGS, 16, number of registers in the bank (2..64; need not be a power of 2).
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- hold, input, 1, 1 = suppress all new grants (pipeline stall / flush).
- req_valid, input, NUM_REQ, per-requester write request.
- req_addr, input, NUM_REQ*ADDR_W, packed target addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_data, input, NUM_REQ*N, packed write data; same slicing with N.
- req_ready, output, NUM_REQ, one-hot grant (combinational).
- reg_en, output, NUM_REGS, one-hot registered write enable to the bank.
- reg_d, output, N, registered write data to the bank.
- addr_err, output, 1, sticky flag: an out-of-range address was granted.

Behaviour:
- Reset (rst=0, async):
  - reg_en=0, reg_d=0, addr_err=0.
  - Round-robin pointer = 0 (requester 0 has highest priority).
  - req_ready is forced to 0 while rst=0.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
  - A requester holds valid/addr/data stable until it is granted.
  - Dropping valid before grant is legal; it is treated as a withdrawn request.
- Arbitration (combinational):
  - If hold=0, search req_valid starting at pointer, wrapping modulo NUM_REQ.
  - The first set bit gets req_ready=1; all other bits are 0.
  - If hold=1 or no request is valid, req_ready=0.
- Pointer update:
  - On a transfer by requester g, pointer <= (g+1) mod NUM_REQ.
  - Otherwise the pointer is unchanged.
- Output stage (latency):
  - Transfer at edge t: reg_en[addr]=1 and reg_d=data during cycle t..t+1; the bank captures at edge t+1.
  - Exactly one write per cycle; back-to-back grants sustain 1 write/cycle.
  - Cycles with no transfer: reg_en=0; reg_d holds its last value.
- Out-of-range address (addr >= NUM_REGS):
  - The transfer still completes (ready=1) to avoid deadlock.
  - reg_en stays 0 for that cycle; addr_err sets and stays set until reset.
- hold asserted mid-stream:
  - A grant already registered still issues its reg_en pulse.
  - No new grant is made while hold=1.
  - The pointer is frozen while hold=1.
- Reset mid-operation: an in-flight reg_en pulse is cleared immediately; the pending write is lost.
- Fairness: with all requesters valid continuously, grants rotate 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 grants.

Optional Feature:
- Macro: REG_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt, NUM_REQ*16 bits: one 16-bit saturating counter per requester.
  - Each counter increments on every transfer by that requester and saturates at 16'hFFFF.
  - Counters clear on reset.
- Undefined: no grant_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Package reg_arb_pkg holds:
  - localparam STATS_W=16;
  - typedef of the saturating counter type;
  - function rr_pick(valid, ptr) returning the grant index and a found bit.
- One natural sub-module: rr_arbiter.
  - Parameter NUM_REQ.
  - Ports: clk, rst, hold, req_valid, req_ready, gnt_idx, gnt_vld.
  - Contents: pointer plus pick logic.
- The top module adds the mux, address decode, output register and error flag.

Test Plan:
- Reset: rst=0 with req_valid=3'b111 -> req_ready=0, reg_en=0, reg_d=0, addr_err=0; release rst -> requester 0 granted first.
- Single write: req 1 valid, addr=5, data=32'h11111 -> req_ready=3'b010 that cycle; next cycle reg_en=16'h0020, reg_d=32'h11111; following cycle reg_en=0.
- Round-robin, all three valid for 6 cycles with data 32'hAAAAA/32'h44444/32'h77777 -> grant order 0,1,2,0,1,2; reg_d follows that order, one write per cycle.
- Hold: hold=1 for 3 cycles with req 2 valid -> req_ready=0 and reg_en=0 after the in-flight pulse; hold=0 -> req 2 granted next cycle.
- Out-of-range: NUM_REGS=12, req 0 addr=14, data=32'hEEEEE -> req_ready[0]=1, reg_en=0, addr_err=1 and held until rst=0.
- With REG_ARB_STATS_EN: 70000 consecutive grants to req 0 -> grant_cnt[15:0]=16'hFFFF; others 0.
